pipeline_control_unit: RTL and testbench

Registered, hazard-aware control unit for the 5-stage MIPS pipeline. It decodes the ID-stage opcode, detects load-use hazards against the instruction in EX, and drives PC/IF-ID write enables and flushes. It launches a one-cycle-latency ID/EX control bundle, inserting bubbles on stall, flush or illegal opcode. Unlike the combinational decoder it supersedes, it handles an extended immediate ALU set and jump/branch squashing, and it counts illegal opcodes.

---
 rtl/pipeline_control_unit_pkg.sv | 50 +++++
 rtl/pipeline_control_unit_opcode_decoder.sv | 74 +++++++
 rtl/pipeline_control_unit.sv | 165 ++++++++++++++++
 tb/tb_pipeline_control_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_control_unit_pkg.sv
// Shared definitions for the ID-stage control unit: opcodes, ALU classes,
// the ID/EX control bundle and the destination-select encoding.
package pipeline_control_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  // Which ID field becomes the EX destination register.
  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_RT   = 2'd1,
    DST_RD   = 2'd2
  } dst_sel_t;

  // Control bundle carried from ID into EX.
  typedef struct packed {
    logic       branch_eq;
    logic       branch_ne;
    logic       jump;
    logic       memory_read;
    logic       memory_write;
    logic       memory_to_register;
    logic       register_write;
    logic       alu_source;
    logic [2:0] alu_opcode;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // True for the immediate ALU ops that can be compiled out.
  function automatic logic is_ext_imm(input logic [5:0] op);
    return (op == OP_SLTI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/pipeline_control_unit_opcode_decoder.sv
// Purely combinational opcode decoder: maps the ID opcode onto the control
// bundle, destination select, rt-as-source flag and an illegal flag.
module pipeline_control_unit_opcode_decoder
  import pipeline_control_unit_pkg::*;
#(
  parameter int EXT_IMM_OPS = 1
) (
  input  logic [5:0] opcode,
  output ctrl_t      ctrl,
  output dst_sel_t   dst_sel,
  output logic       uses_rt,
  output logic       illegal
);

  // Table decode; extended immediates fall back to illegal when disabled.
  always_comb begin
    ctrl    = CTRL_BUBBLE;
    dst_sel = DST_NONE;
    uses_rt = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.register_write = 1'b1;
        ctrl.alu_opcode     = ALU_FUNCT;
        dst_sel             = DST_RD;
        uses_rt             = 1'b1;
      end
      OP_J: ctrl.jump = 1'b1;
      OP_BEQ: begin
        ctrl.branch_eq  = 1'b1;
        ctrl.alu_opcode = ALU_SUB;
        uses_rt         = 1'b1;
      end
      OP_BNE: begin
        ctrl.branch_ne  = 1'b1;
        ctrl.alu_opcode = ALU_SUB;
        uses_rt         = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        ctrl.register_write = 1'b1;
        ctrl.alu_source     = 1'b1;
        dst_sel             = DST_RT;
        case (opcode)
          OP_SLTI: ctrl.alu_opcode = ALU_SLT;
          OP_ANDI: ctrl.alu_opcode = ALU_AND;
          OP_ORI:  ctrl.alu_opcode = ALU_OR;
          default: ctrl.alu_opcode = ALU_ADD;
        endcase
      end
      OP_LW: begin
        ctrl.memory_read        = 1'b1;
        ctrl.memory_to_register = 1'b1;
        ctrl.register_write     = 1'b1;
        ctrl.alu_source         = 1'b1;
        ctrl.alu_opcode         = ALU_ADD;
        dst_sel                 = DST_RT;
      end
      OP_SW: begin
        ctrl.memory_write = 1'b1;
        ctrl.alu_source   = 1'b1;
        ctrl.alu_opcode   = ALU_ADD;
        uses_rt           = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if ((EXT_IMM_OPS == 0) && is_ext_imm(opcode)) begin
      ctrl    = CTRL_BUBBLE;
      dst_sel = DST_NONE;
      uses_rt = 1'b0;
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Hazard-aware pipeline control: load-use stall, branch/jump squash,
// registered ID/EX control bundle and a saturating illegal-opcode counter.
module pipeline_control_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int EXT_IMM_OPS    = 1,
  parameter int LOAD_USE_STALL = 1,
  parameter int ILLEGAL_CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [5:0]               opcode,
  input  logic [REG_ADDR_W-1:0]    rs,
  input  logic [REG_ADDR_W-1:0]    rt,
  input  logic [REG_ADDR_W-1:0]    rd,
  input  logic                     ex_branch_taken,
  input  logic                     ex_stall,
  output logic                     pc_write,
  output logic                     if_id_write,
  output logic                     if_id_flush,
  output logic                     ex_valid,
  output logic                     ex_branch_eq,
  output logic                     ex_branch_ne,
  output logic                     ex_jump,
  output logic                     ex_memory_read,
  output logic                     ex_memory_write,
  output logic                     ex_memory_to_register,
  output logic                     ex_register_write,
  output logic                     ex_alu_source,
  output logic [2:0]               ex_alu_opcode,
  output logic [REG_ADDR_W-1:0]    ex_write_reg,
  output logic [REG_ADDR_W-1:0]    ex_rs,
  output logic [REG_ADDR_W-1:0]    ex_rt,
  output logic                     illegal_opcode,
  output logic [ILLEGAL_CNT_W-1:0] illegal_count
);

  localparam logic [ILLEGAL_CNT_W-1:0] CNT_ONE = {{(ILLEGAL_CNT_W-1){1'b0}}, 1'b1};

  ctrl_t                   id_ctrl;
  dst_sel_t                id_dst;
  logic                    id_uses_rt;
  logic                    id_illegal;
  logic [REG_ADDR_W-1:0]   id_write_reg;
  logic                    load_use;

  ctrl_t                   ctrl_q, ctrl_d;
  logic                    valid_q, valid_d;
  logic [REG_ADDR_W-1:0]   write_reg_q, write_reg_d;
  logic [REG_ADDR_W-1:0]   rs_q, rs_d;
  logic [REG_ADDR_W-1:0]   rt_q, rt_d;
  logic                    illegal_q, illegal_d;
  logic [ILLEGAL_CNT_W-1:0] count_q, count_d;

  pipeline_control_unit_opcode_decoder #(
    .EXT_IMM_OPS(EXT_IMM_OPS)
  ) u_decoder (
    .opcode  (opcode),
    .ctrl    (id_ctrl),
    .dst_sel (id_dst),
    .uses_rt (id_uses_rt),
    .illegal (id_illegal)
  );

  // Select the destination register field and detect a load-use hazard.
  always_comb begin
    case (id_dst)
      DST_RD:  id_write_reg = rd;
      DST_RT:  id_write_reg = rt;
      default: id_write_reg = '0;
    endcase
    load_use = (LOAD_USE_STALL != 0) && id_valid && valid_q && ctrl_q.memory_read &&
               (write_reg_q != '0) &&
               ((write_reg_q == rs) || (id_uses_rt && (write_reg_q == rt)));
  end

  // Front-end write enables and flush, ordered by hazard priority.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    if (reset) begin
      pc_write    = 1'b1;
    end else if (ex_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else begin
      if_id_flush = id_valid && !id_illegal && id_ctrl.jump;
    end
  end

  // Next ID/EX contents: hold on stall, bubble on squash/hazard/illegal.
  always_comb begin
    ctrl_d      = CTRL_BUBBLE;
    valid_d     = 1'b0;
    write_reg_d = '0;
    rs_d        = '0;
    rt_d        = '0;
    illegal_d   = 1'b0;
    count_d     = count_q;
    if (ex_stall) begin
      ctrl_d      = ctrl_q;
      valid_d     = valid_q;
      write_reg_d = write_reg_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
    end else if (ex_branch_taken || load_use || !id_valid) begin
      valid_d = 1'b0;
    end else if (id_illegal) begin
      illegal_d = 1'b1;
      if (count_q != '1) count_d = count_q + CNT_ONE;
    end else begin
      ctrl_d      = id_ctrl;
      valid_d     = 1'b1;
      write_reg_d = id_write_reg;
      rs_d        = rs;
      rt_d        = rt;
    end
  end

  // ID/EX pipeline register and counter with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q      <= CTRL_BUBBLE;
      valid_q     <= 1'b0;
      write_reg_q <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      illegal_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      valid_q     <= valid_d;
      write_reg_q <= write_reg_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      illegal_q   <= illegal_d;
      count_q     <= count_d;
    end
  end

  assign ex_valid              = valid_q;
  assign ex_branch_eq          = ctrl_q.branch_eq;
  assign ex_branch_ne          = ctrl_q.branch_ne;
  assign ex_jump               = ctrl_q.jump;
  assign ex_memory_read        = ctrl_q.memory_read;
  assign ex_memory_write       = ctrl_q.memory_write;
  assign ex_memory_to_register = ctrl_q.memory_to_register;
  assign ex_register_write     = ctrl_q.register_write;
  assign ex_alu_source         = ctrl_q.alu_source;
  assign ex_alu_opcode         = ctrl_q.alu_opcode;
  assign ex_write_reg          = write_reg_q;
  assign ex_rs                 = rs_q;
  assign ex_rt                 = rt_q;
  assign illegal_opcode        = illegal_q;
  assign illegal_count         = count_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit: directed vectors push their
// hand-computed expectations; a monitor pops and compares every cycle.
module tb_pipeline_control_unit;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // {beq, bne, jump, mem_read, mem_write, mem_to_reg, reg_write, alu_src, alu[2:0]}
  localparam logic [10:0] C_BUB  = 11'b00000000000;
  localparam logic [10:0] C_ADDI = 11'b00000011000;
  localparam logic [10:0] C_R    = 11'b00000010010;
  localparam logic [10:0] C_LW   = 11'b00010111000;
  localparam logic [10:0] C_SW   = 11'b00001001000;
  localparam logic [10:0] C_BEQ  = 11'b10000000001;
  localparam logic [10:0] C_J    = 11'b00100000000;
  localparam logic [10:0] C_ORI  = 11'b00000011100;
  localparam logic [10:0] C_ANDI = 11'b00000011011;

  // {pc_write, if_id_write, if_id_flush}
  localparam logic [2:0] K_RUN = 3'b110;
  localparam logic [2:0] K_FRZ = 3'b000;
  localparam logic [2:0] K_FLS = 3'b111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [5:0] opcode = 6'b0;
  logic [4:0] rs = 5'd0, rt = 5'd0, rd = 5'd0;
  logic       ex_branch_taken = 1'b0;
  logic       ex_stall = 1'b0;

  logic       pc_write, if_id_write, if_id_flush, ex_valid;
  logic       ex_branch_eq, ex_branch_ne, ex_jump, ex_memory_read, ex_memory_write;
  logic       ex_memory_to_register, ex_register_write, ex_alu_source;
  logic [2:0] ex_alu_opcode;
  logic [4:0] ex_write_reg, ex_rs, ex_rt;
  logic       illegal_opcode;
  logic [7:0] illegal_count;

  logic       nx_pc_write, nx_if_id_write, nx_if_id_flush, nx_ex_valid;
  logic       nx_beq, nx_bne, nx_jump, nx_mr, nx_mw, nx_m2r, nx_rw, nx_asrc;
  logic [2:0] nx_alu;
  logic [4:0] nx_wr, nx_rs, nx_rt;
  logic       nx_illegal_opcode;
  logic [7:0] nx_illegal_count;

  pipeline_control_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd),
    .ex_branch_taken(ex_branch_taken), .ex_stall(ex_stall),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .ex_valid(ex_valid), .ex_branch_eq(ex_branch_eq), .ex_branch_ne(ex_branch_ne),
    .ex_jump(ex_jump), .ex_memory_read(ex_memory_read), .ex_memory_write(ex_memory_write),
    .ex_memory_to_register(ex_memory_to_register), .ex_register_write(ex_register_write),
    .ex_alu_source(ex_alu_source), .ex_alu_opcode(ex_alu_opcode),
    .ex_write_reg(ex_write_reg), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .illegal_opcode(illegal_opcode), .illegal_count(illegal_count)
  );

  pipeline_control_unit #(.EXT_IMM_OPS(0)) dut_noext (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd),
    .ex_branch_taken(ex_branch_taken), .ex_stall(ex_stall),
    .pc_write(nx_pc_write), .if_id_write(nx_if_id_write), .if_id_flush(nx_if_id_flush),
    .ex_valid(nx_ex_valid), .ex_branch_eq(nx_beq), .ex_branch_ne(nx_bne),
    .ex_jump(nx_jump), .ex_memory_read(nx_mr), .ex_memory_write(nx_mw),
    .ex_memory_to_register(nx_m2r), .ex_register_write(nx_rw),
    .ex_alu_source(nx_asrc), .ex_alu_opcode(nx_alu),
    .ex_write_reg(nx_wr), .ex_rs(nx_rs), .ex_rt(nx_rt),
    .illegal_opcode(nx_illegal_opcode), .illegal_count(nx_illegal_count)
  );

  typedef struct {
    int          idx;
    logic [2:0]  comb;
    logic        valid;
    logic [10:0] ctrl;
    logic [4:0]  wr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        ill;
    logic [7:0]  cnt;
    logic        nx_ill;
    logic [7:0]  nx_cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   vec_n = 0;

  function automatic logic [7:0] sat8(input int x);
    return (x > 255) ? 8'd255 : x[7:0];
  endfunction

  task automatic checkOutput(input string name, input int idx,
                             input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s vec%0d: got %h want %h", name, idx, got, want);
    end
  endtask

  task automatic applyStimulus(
    input logic r, input logic v, input logic [5:0] op,
    input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
    input logic b, input logic st,
    input logic [2:0] e_comb, input logic e_valid, input logic [10:0] e_ctrl,
    input logic [4:0] e_wr, input logic [4:0] e_rs, input logic [4:0] e_rt,
    input logic e_ill, input logic [7:0] e_cnt,
    input logic e_nx_ill, input logic [7:0] e_nx_cnt);
    exp_t e;
    @(negedge clk);
    reset = r; id_valid = v; opcode = op;
    rs = s; rt = t; rd = d;
    ex_branch_taken = b; ex_stall = st;
    e.idx = vec_n; e.comb = e_comb; e.valid = e_valid; e.ctrl = e_ctrl;
    e.wr = e_wr; e.rs = e_rs; e.rt = e_rt; e.ill = e_ill; e.cnt = e_cnt;
    e.nx_ill = e_nx_ill; e.nx_cnt = e_nx_cnt;
    sb.push_back(e);
    vec_n++;
  endtask

  // Monitor: combinational outputs late in the cycle, registered ones after the edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        checkOutput("front_end", mon_e.idx, {61'd0, pc_write, if_id_write, if_id_flush},
                    {61'd0, mon_e.comb});
        @(posedge clk);
        #1;
        checkOutput("ex_ctrl", mon_e.idx,
                    {52'd0, ex_valid, ex_branch_eq, ex_branch_ne, ex_jump, ex_memory_read,
                     ex_memory_write, ex_memory_to_register, ex_register_write,
                     ex_alu_source, ex_alu_opcode},
                    {52'd0, mon_e.valid, mon_e.ctrl});
        checkOutput("ex_regs", mon_e.idx, {49'd0, ex_write_reg, ex_rs, ex_rt},
                    {49'd0, mon_e.wr, mon_e.rs, mon_e.rt});
        checkOutput("illegal", mon_e.idx, {55'd0, illegal_opcode, illegal_count},
                    {55'd0, mon_e.ill, mon_e.cnt});
        checkOutput("noext_illegal", mon_e.idx, {55'd0, nx_illegal_opcode, nx_illegal_count},
                    {55'd0, mon_e.nx_ill, mon_e.nx_cnt});
      end
    end
  end

  initial begin
    // reset, including reset overriding a valid ADDI
    applyStimulus(1,0,OP_R,   0,0,0, 0,0, K_RUN, 0,C_BUB, 0,0,0, 0,0, 0,0);
    applyStimulus(1,1,OP_ADDI,1,3,7, 0,0, K_RUN, 0,C_BUB, 0,0,0, 0,0, 0,0);
    // ADDI rt=3
    applyStimulus(0,1,OP_ADDI,1,3,7, 0,0, K_RUN, 1,C_ADDI,3,1,3, 0,0, 0,0);
    // LW rt=5 then R rs=5: one-cycle stall, then R issues with rd
    applyStimulus(0,1,OP_LW,  2,5,0, 0,0, K_RUN, 1,C_LW,  5,2,5, 0,0, 0,0);
    applyStimulus(0,1,OP_R,   5,6,9, 0,0, K_FRZ, 0,C_BUB, 0,0,0, 0,0, 0,0);
    applyStimulus(0,1,OP_R,   5,6,9, 0,0, K_RUN, 1,C_R,   9,5,6, 0,0, 0,0);
    // LW rt=0 then R rs=0: no stall
    applyStimulus(0,1,OP_LW,  1,0,0, 0,0, K_RUN, 1,C_LW,  0,1,0, 0,0, 0,0);
    applyStimulus(0,1,OP_R,   0,0,4, 0,0, K_RUN, 1,C_R,   4,0,0, 0,0, 0,0);
    // BEQ into EX, then taken with stall held, then release
    applyStimulus(0,1,OP_BEQ, 1,2,0, 0,0, K_RUN, 1,C_BEQ, 0,1,2, 0,0, 0,0);
    applyStimulus(0,1,OP_ORI, 3,4,0, 1,1, K_FRZ, 1,C_BEQ, 0,1,2, 0,0, 0,0);
    applyStimulus(0,1,OP_ORI, 3,4,0, 1,1, K_FRZ, 1,C_BEQ, 0,1,2, 0,0, 0,0);
    applyStimulus(0,1,OP_ORI, 3,4,0, 1,0, K_FLS, 0,C_BUB, 0,0,0, 0,0, 0,0);
    applyStimulus(0,1,OP_ORI, 3,4,0, 0,0, K_RUN, 1,C_ORI, 4,3,4, 0,0, 1,1);
    // J: flush same cycle, jump enters EX
    applyStimulus(0,1,OP_J,   0,0,0, 0,0, K_FLS, 1,C_J,   0,0,0, 0,0, 0,1);
    // ANDI: legal here, illegal in the no-extension instance
    applyStimulus(0,1,OP_ANDI,1,2,0, 0,0, K_RUN, 1,C_ANDI,2,1,2, 0,0, 1,2);
    // branch flush beats a simultaneous load-use hazard
    applyStimulus(0,1,OP_LW,  0,7,0, 0,0, K_RUN, 1,C_LW,  7,0,7, 0,0, 0,2);
    applyStimulus(0,1,OP_SW,  1,7,0, 1,0, K_FLS, 0,C_BUB, 0,0,0, 0,0, 0,2);
    // load-use through rt of a store
    applyStimulus(0,1,OP_LW,  0,7,0, 0,0, K_RUN, 1,C_LW,  7,0,7, 0,0, 0,2);
    applyStimulus(0,1,OP_SW,  1,7,0, 0,0, K_FRZ, 0,C_BUB, 0,0,0, 0,0, 0,2);
    applyStimulus(0,1,OP_SW,  1,7,0, 0,0, K_RUN, 1,C_SW,  0,1,7, 0,0, 0,2);
    // illegal opcode with id_valid low is ignored
    applyStimulus(0,0,OP_BAD, 0,0,0, 0,0, K_RUN, 0,C_BUB, 0,0,0, 0,0, 0,2);
    // 300 illegal opcodes: counter saturates at 255
    for (int i = 0; i < 300; i++)
      applyStimulus(0,1,OP_BAD,0,0,0, 0,0, K_RUN, 0,C_BUB, 0,0,0,
                    1, sat8(i + 1), 1, sat8(i + 3));
    applyStimulus(0,1,OP_ADDI,1,2,0, 0,0, K_RUN, 1,C_ADDI,2,1,2, 0,8'd255, 0,8'd255);
    // reset during a pending load-use stall clears everything
    applyStimulus(0,1,OP_LW,  0,5,0, 0,0, K_RUN, 1,C_LW,  5,0,5, 0,8'd255, 0,8'd255);
    applyStimulus(1,1,OP_R,   5,6,9, 0,0, K_RUN, 0,C_BUB, 0,0,0, 0,0, 0,0);
    applyStimulus(0,1,OP_R,   5,6,9, 0,0, K_RUN, 1,C_R,   9,5,6, 0,0, 0,0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
